// File: rtl/verdict_pkg.sv
// Shared types and helpers for the verdict collector: snapshot layout, serializer states,
// drop-counter width and the lowest-set-bit search. Honours VERDICT_TIMESTAMP_EN.
package verdict_pkg;

    localparam int DROP_CNT_W = 16;

    // Default geometry; the top re-declares the snapshot at its own parameter widths.
    localparam int VD_NUM_OUTPUTS = 4;
    localparam int VD_DATA_W      = 64;
    localparam int VD_TS_W        = 32;

    // Widest mask the lowest-set-bit search handles.
    localparam int LSB_MAX_W = 32;

    typedef struct packed {
`ifdef VERDICT_TIMESTAMP_EN
        logic [VD_TS_W-1:0]                  ts;
`endif
        logic [VD_NUM_OUTPUTS-1:0]           mask;
        logic [VD_NUM_OUTPUTS*VD_DATA_W-1:0] values;
    } snapshot_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

    function automatic logic [4:0] lsb_index(input logic [LSB_MAX_W-1:0] mask);
        lsb_index = 5'd0;
        for (int i = LSB_MAX_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lsb_index = 5'(i);
            end
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and no write-to-read bypass.
// A pop never frees space for a push in the same cycle because full is the registered flag.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next occupancy from the qualified push/pop pair.
    always_comb begin
        count_nx_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Pointers, occupancy and the registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CNT_W'(DEPTH));
            empty_r <= (count_nx_s == {CNT_W{1'b0}});
        end
    end

    // Storage array; contents need no reset since the flags gate every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/verdict_collector.sv
// Snapshots active RTLola monitor outputs into a FIFO and serializes them as records.
// Define VERDICT_TIMESTAMP_EN to carry a timestamp per snapshot; otherwise rec_ts is 0.
module verdict_collector
    import verdict_pkg::*;
#(
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_W      = 64,
    parameter int TS_W        = 32,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [$clog2(NUM_OUTPUTS)-1:0] rec_idx,
    output logic [DATA_W-1:0]             rec_data,
    output logic [TS_W-1:0]               rec_ts,
    output logic                          rec_last,
    output logic                          overflow,
    output logic [DROP_CNT_W-1:0]         drop_cnt
);

    localparam int IDX_W = $clog2(NUM_OUTPUTS);
    localparam int VAL_W = NUM_OUTPUTS * DATA_W;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
    localparam logic [NUM_OUTPUTS-1:0] MASK_ZERO = {NUM_OUTPUTS{1'b0}};

    typedef struct packed {
`ifdef VERDICT_TIMESTAMP_EN
        logic [TS_W-1:0]        ts;
`endif
        logic [NUM_OUTPUTS-1:0] mask;
        logic [VAL_W-1:0]       values;
    } snap_t;

    localparam int ENTRY_W = $bits(snap_t);

    snap_t                   wr_entry_s;
    snap_t                   head_s;
    logic [ENTRY_W-1:0]      head_vec_s;
    logic                    capture_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;

    ser_state_t              state_r;
    ser_state_t              state_nx_s;
    snap_t                   hold_r;
    snap_t                   hold_nx_s;
    logic [NUM_OUTPUTS-1:0]  low_bit_s;
    logic [NUM_OUTPUTS-1:0]  rem_mask_s;
    logic                    handshake_s;

    logic                    rec_valid_r;
    logic [IDX_W-1:0]        rec_idx_r;
    logic [DATA_W-1:0]       rec_data_r;
    logic                    rec_last_r;
    logic                    rec_valid_nx_s;
    logic [IDX_W-1:0]        rec_idx_nx_s;
    logic [DATA_W-1:0]       rec_data_nx_s;
    logic                    rec_last_nx_s;
    logic                    overflow_r;
    logic [DROP_CNT_W-1:0]   drop_cnt_r;

    assign capture_s         = en && (out_aktv != MASK_ZERO);
    assign push_s            = capture_s && !fifo_full_s;
    assign wr_entry_s.mask   = out_aktv;
    assign wr_entry_s.values = out_data;
    assign head_s            = head_vec_s;

`ifdef VERDICT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;
    logic [TS_W-1:0] rec_ts_r;
    logic [TS_W-1:0] rec_ts_nx_s;

    assign wr_entry_s.ts = ts_r;
    assign rec_ts        = rec_ts_r;

    // Free-running event-time counter, advancing only in enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r <= {TS_W{1'b0}};
        end else if (en) begin
            ts_r <= ts_r + TS_W'(1);
        end
    end
`else
    assign rec_ts = {TS_W{1'b0}};
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (wr_entry_s),
        .pop       (pop_s),
        .pop_data  (head_vec_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Sticky overflow flag and saturating drop counter for snapshots refused by a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (capture_s && fifo_full_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
            end
        end
    end

    // hold_r.mask keeps the bits still to emit, including the one currently presented.
    assign handshake_s = rec_valid_r && rec_ready;
    assign low_bit_s   = hold_r.mask & (~hold_r.mask + NUM_OUTPUTS'(1));
    assign rem_mask_s  = hold_r.mask & ~low_bit_s;

    // Serializer next state: load from the FIFO, retire one bit per handshake.
    always_comb begin
        state_nx_s = state_r;
        hold_nx_s  = hold_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    hold_nx_s  = head_s;
                    state_nx_s = EMIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EMIT: begin
                if (handshake_s) begin
                    if (rem_mask_s != MASK_ZERO) begin
                        hold_nx_s.mask = rem_mask_s;
                    end else if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        hold_nx_s = head_s;
                    end else begin
                        hold_nx_s.mask = MASK_ZERO;
                        state_nx_s     = IDLE;
                    end
                end else begin
                    state_nx_s = EMIT;
                end
            end
            default: begin
                hold_nx_s.mask = MASK_ZERO;
                state_nx_s     = IDLE;
            end
        endcase
    end

    // Record fields derived from the next held snapshot so the outputs can be registered.
    always_comb begin
        rec_valid_nx_s = (state_nx_s == EMIT);
        rec_idx_nx_s   = {IDX_W{1'b0}};
        rec_data_nx_s  = {DATA_W{1'b0}};
        rec_last_nx_s  = 1'b0;
`ifdef VERDICT_TIMESTAMP_EN
        rec_ts_nx_s    = {TS_W{1'b0}};
`endif
        if (rec_valid_nx_s) begin
            rec_idx_nx_s  = IDX_W'(lsb_index(LSB_MAX_W'(hold_nx_s.mask)));
            rec_data_nx_s = hold_nx_s.values[rec_idx_nx_s*DATA_W +: DATA_W];
            rec_last_nx_s = ((hold_nx_s.mask & (hold_nx_s.mask - NUM_OUTPUTS'(1))) == MASK_ZERO);
`ifdef VERDICT_TIMESTAMP_EN
            rec_ts_nx_s   = hold_nx_s.ts;
`endif
        end else begin
            rec_last_nx_s = 1'b0;
        end
    end

    // Serializer state, holding register and registered record outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            hold_r      <= {ENTRY_W{1'b0}};
            rec_valid_r <= 1'b0;
            rec_idx_r   <= {IDX_W{1'b0}};
            rec_data_r  <= {DATA_W{1'b0}};
            rec_last_r  <= 1'b0;
`ifdef VERDICT_TIMESTAMP_EN
            rec_ts_r    <= {TS_W{1'b0}};
`endif
        end else begin
            state_r     <= state_nx_s;
            hold_r      <= hold_nx_s;
            rec_valid_r <= rec_valid_nx_s;
            rec_idx_r   <= rec_idx_nx_s;
            rec_data_r  <= rec_data_nx_s;
            rec_last_r  <= rec_last_nx_s;
`ifdef VERDICT_TIMESTAMP_EN
            rec_ts_r    <= rec_ts_nx_s;
`endif
        end
    end

    assign rec_valid = rec_valid_r;
    assign rec_idx   = rec_idx_r;
    assign rec_data  = rec_data_r;
    assign rec_last  = rec_last_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_verdict_collector.sv
// Directed scoreboard bench for verdict_collector (TS_W=8 so counter wrap is reachable).
module tb_verdict_collector;

    localparam int NO = 4;
    localparam int DW = 64;
    localparam int TW = 8;
`ifdef VERDICT_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [NO*DW-1:0] out_data = '0;
    logic [NO-1:0]   out_aktv = '0;
    logic            rec_valid;
    logic            rec_ready = 1'b1;
    logic [1:0]      rec_idx;
    logic [DW-1:0]   rec_data;
    logic [TW-1:0]   rec_ts;
    logic            rec_last;
    logic            overflow;
    logic [15:0]     drop_cnt;

    typedef struct packed {
        logic [1:0]    idx;
        logic [DW-1:0] data;
        logic [TW-1:0] ts;
        logic          last;
    } rec_t;

    rec_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] ts_model = 8'd0;

    verdict_collector #(
        .NUM_OUTPUTS (NO),
        .DATA_W      (DW),
        .TS_W        (TW),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .out_data  (out_data),
        .out_aktv  (out_aktv),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_idx   (rec_idx),
        .rec_data  (rec_data),
        .rec_ts    (rec_ts),
        .rec_last  (rec_last),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_ts();
        return TS_ON ? ts_model : 8'd0;
    endfunction

    // One clock; a handshake seen before the edge is scored against the queue head.
    task automatic cycle();
        logic hs;
        rec_t got;
        rec_t e;
        hs = rec_valid && rec_ready;
        got.idx = rec_idx; got.data = rec_data; got.ts = rec_ts; got.last = rec_last;
        @(posedge clk);
        if (en && !rst) ts_model = ts_model + 8'd1;
        #1;
        if (hs) begin
            check("record_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rec_idx", 64'(got.idx), 64'(e.idx));
                check("rec_data", got.data, e.data);
                check("rec_ts", 64'(got.ts), 64'(e.ts));
                check("rec_last", 64'(got.last), 64'(e.last));
            end
        end
    endtask

    // Drive one capture cycle; unless dropped, queue one record per active output.
    task automatic ev(input logic [3:0] aktv, input logic [63:0] v0, input logic [63:0] v1,
                      input logic [63:0] v2, input logic [63:0] v3, input bit dropped);
        logic [63:0] vals [4];
        rec_t r;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        en = 1'b1;
        out_aktv = aktv;
        out_data = {v3, v2, v1, v0};
        if (!dropped) begin
            for (int i = 0; i < 4; i++) begin
                if (aktv[i]) begin
                    r.idx  = 2'(i);
                    r.data = vals[i];
                    r.ts   = exp_ts();
                    r.last = ((aktv >> (i + 1)) == 4'd0);
                    exp_q.push_back(r);
                end
            end
        end
        cycle();
        out_aktv = 4'b0000;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rec_valid) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(rec_valid), 64'd0);
        check({tag, "_idx"}, 64'(rec_idx), 64'd0);
        check({tag, "_data"}, rec_data, 64'd0);
        check({tag, "_ts"}, 64'(rec_ts), 64'd0);
        check({tag, "_last"}, 64'(rec_last), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    endtask

    initial begin
        // Reset state.
        cycle();
        cycle();
        check_zero("reset");
        rst = 1'b0;
        ts_model = 8'd0;
        en = 1'b1;

        // Single event at ts=50 with the two-edge latency.
        for (int k = 0; k < 60 && ts_model != 8'd50; k++) cycle();
        ev(4'b0010, 64'h1111, 64'd5, 64'h3333, 64'h4444, 1'b0);
        check("latency_not_yet", 64'(rec_valid), 64'd0);
        cycle();
        check("latency_valid", 64'(rec_valid), 64'd1);
        check("single_ts", 64'(rec_ts), TS_ON ? 64'd50 : 64'd0);
        drain(20);

        // Multiple active outputs, negative value passes through unextended.
        ev(4'b1011, 64'd7, -64'sd3, 64'hBAD0BAD0, 64'd9, 1'b0);
        drain(20);

        // Backpressure: fields held for ten cycles, accepted on first ready.
        rec_ready = 1'b0;
        ev(4'b0101, 64'hA5A5, 64'h0, 64'hC3C3_0000_0000_0001, 64'h0, 1'b0);
        for (int k = 0; k < 8 && !rec_valid; k++) cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("hold_valid", 64'(rec_valid), 64'd1);
            check("hold_idx", 64'(rec_idx), 64'(exp_q[0].idx));
            check("hold_data", rec_data, exp_q[0].data);
            check("hold_last", 64'(rec_last), 64'(exp_q[0].last));
        end
        rec_ready = 1'b1;
        drain(20);

        // Two snapshots on consecutive edges stream without a bubble.
        ev(4'b0011, 64'd21, 64'd22, 64'd0, 64'd0, 1'b0);
        ev(4'b0100, 64'd0, 64'd0, 64'd23, 64'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("no_bubble", 64'(rec_valid), 64'd1);
            cycle();
        end
        drain(20);

        // Overflow: one snapshot sits in the serializer, sixteen fill the FIFO, the 18th drops.
        rec_ready = 1'b0;
        for (int k = 1; k <= 17; k++) ev(4'b0001, 64'(k), 64'd0, 64'd0, 64'd0, 1'b0);
        check("no_overflow_yet", 64'(overflow), 64'd0);
        ev(4'b0001, 64'd18, 64'd0, 64'd0, 64'd0, 1'b1);
        check("overflow_set", 64'(overflow), 64'd1);
        check("drop_cnt_one", 64'(drop_cnt), 64'd1);
        rec_ready = 1'b1;
        drain(60);
        check("overflow_sticky", 64'(overflow), 64'd1);

        // Reset during emission of a three-record snapshot with two more queued.
        rec_ready = 1'b0;
        ev(4'b0111, 64'd31, 64'd32, 64'd33, 64'd0, 1'b0);
        ev(4'b0001, 64'd34, 64'd0, 64'd0, 64'd0, 1'b0);
        ev(4'b0010, 64'd0, 64'd35, 64'd0, 64'd0, 1'b0);
        for (int k = 0; k < 8 && !rec_valid; k++) cycle();
        check("pre_reset_valid", 64'(rec_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        cycle();
        rst = 1'b0;
        ts_model = 8'd0;
        rec_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("quiet_after_reset", 64'(rec_valid), 64'd0);
        end

        // Timestamp wrap: event after 300 enabled cycles carries 300 mod 256.
        for (int k = 20; k < 300; k++) cycle();
        ev(4'b1000, 64'd0, 64'd0, 64'd0, 64'h44, 1'b0);
        cycle();
        check("wrap_ts", 64'(rec_ts), TS_ON ? 64'd44 : 64'd0);
        drain(20);

        // No capture and no counting while disabled.
        en = 1'b0;
        out_aktv = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("disabled_no_record", 64'(rec_valid), 64'd0);
        end
        ev(4'b0100, 64'd0, 64'd0, 64'h5A, 64'd0, 1'b0);
        drain(20);

        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
